// File: rtl/dcpu16_pkg.sv
// Shared DCPU16 definitions: fetch-stage state encoding, effective-address
// operand codes and the basic/non-basic opcode marker.
package dcpu16_pkg;

   // Fetch-stage sequencer states.
   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_NWA    = 3'd2,
      ST_NWB    = 3'd3,
      ST_HOLD   = 3'd4
   } fbus_state_e;

   // Effective-address operand codes (6-bit a/b fields).
   localparam logic [5:0] EA_REG  = 6'h00;  // 0x00-0x07 register
   localparam logic [5:0] EA_IND  = 6'h08;  // 0x08-0x0f [register]
   localparam logic [5:0] EA_IDX  = 6'h10;  // 0x10-0x17 [next word + register]
   localparam logic [5:0] EA_POP  = 6'h18;
   localparam logic [5:0] EA_PEEK = 6'h19;
   localparam logic [5:0] EA_PUSH = 6'h1a;
   localparam logic [5:0] EA_SP   = 6'h1b;
   localparam logic [5:0] EA_PC   = 6'h1c;
   localparam logic [5:0] EA_O    = 6'h1d;
   localparam logic [5:0] EA_NWI  = 6'h1e;  // [next word]
   localparam logic [5:0] EA_NWL  = 6'h1f;  // next word literal

   // A zero opcode field marks a non-basic instruction; ea_a is then a sub-opcode.
   localparam logic [3:0] OPC_NONBASIC = 4'h0;

   // True when an ea code consumes one extra word from the instruction stream.
   function automatic logic ea_needs_next_word(input logic [5:0] ea);
      logic need;
      if ((ea >= EA_IDX) && (ea < EA_POP)) begin
         need = 1'b1;
      end else if ((ea == EA_NWI) || (ea == EA_NWL)) begin
         need = 1'b1;
      end else begin
         need = 1'b0;
      end
      return need;
   endfunction

endpackage

// File: rtl/dcpu16_nwdet.sv
// Combinational detector: does an ea operand code require a next word?
// Shared between the fetch stage and the A/B bus address calculator.
module dcpu16_nwdet
   import dcpu16_pkg::*;
(
   input  logic [5:0] ea_i,
   output logic       need_o
);

   // Classify the operand code.
   always_comb begin
      need_o = 1'b0;
      if (ea_needs_next_word(ea_i)) begin
         need_o = 1'b1;
      end else begin
         need_o = 1'b0;
      end
   end

endmodule

// File: rtl/dcpu16_fbus.sv
// DCPU16 instruction fetch stage. Owns the PC, reads the instruction word and
// any operand next words over a read-only Simplified Wishbone port, and hands
// a complete instruction bundle downstream with a valid/ready handshake.
// pc_ld (branch/skip) flushes whatever is in flight and restarts at pc_dat.
module dcpu16_fbus
   import dcpu16_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
)(
   input  logic        clk,
   input  logic        rst,
   // fetch bus
   output logic [15:0] fb_adr,
   output logic        fb_stb,
   output logic        fb_ena,
   output logic        fb_wre,
   input  logic [15:0] fb_dti,
   input  logic        fb_ack,
   // PC control
   input  logic        pc_ld,
   input  logic [15:0] pc_dat,
   output logic [15:0] regPC,
   // instruction bundle
   output logic [3:0]  opc,
   output logic [5:0]  ea_a,
   output logic [5:0]  ea_b,
   output logic [15:0] nwa,
   output logic [15:0] nwb,
   output logic        dec_vld,
   input  logic        dec_rdy
);

   fbus_state_e state_q, state_d;
   logic [15:0] regpc_q, regpc_d;
   logic [15:0] adr_q,   adr_d;
   logic        stb_q,   stb_d;
   logic        vld_q,   vld_d;
   logic [3:0]  opc_q,   opc_d;
   logic [5:0]  ea_a_q,  ea_a_d;
   logic [5:0]  ea_b_q,  ea_b_d;
   logic [15:0] nwa_q,   nwa_d;
   logic [15:0] nwb_q,   nwb_d;

   logic        need_a_raw_s;
   logic        need_a_s;
   logic        need_b_s;
   logic        bus_ack_s;

   // Next-word requirement of each operand of the captured instruction.
   dcpu16_nwdet u_nwdet_a (
      .ea_i   (ea_a_q),
      .need_o (need_a_raw_s)
   );

   dcpu16_nwdet u_nwdet_b (
      .ea_i   (ea_b_q),
      .need_o (need_b_s)
   );

   // For non-basic instructions ea_a is a sub-opcode, never an operand.
   assign need_a_s  = need_a_raw_s & (opc_q != OPC_NONBASIC);

   // An ack only counts while our strobe is actually out.
   assign bus_ack_s = stb_q & fb_ack;

   // Sequencer next state, PC, bus request and bundle capture.
   always_comb begin
      state_d = state_q;
      regpc_d = regpc_q;
      adr_d   = adr_q;
      stb_d   = stb_q;
      vld_d   = vld_q;
      opc_d   = opc_q;
      ea_a_d  = ea_a_q;
      ea_b_d  = ea_b_q;
      nwa_d   = nwa_q;
      nwb_d   = nwb_q;

      if (pc_ld) begin
         // Flush: any coincident ack or downstream accept is discarded.
         state_d = ST_FETCH;
         regpc_d = pc_dat;
         stb_d   = 1'b0;
         vld_d   = 1'b0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (bus_ack_s) begin
                  opc_d   = fb_dti[3:0];
                  ea_a_d  = fb_dti[9:4];
                  ea_b_d  = fb_dti[15:10];
                  regpc_d = regpc_q + 16'd1;
                  stb_d   = 1'b0;
                  state_d = ST_DECODE;
               end else begin
                  // Raise (or keep) the request for the word at the PC.
                  stb_d   = 1'b1;
                  adr_d   = regpc_q;
               end
            end

            ST_DECODE: begin
               nwa_d = 16'h0000;
               nwb_d = 16'h0000;
               if (need_a_s) begin
                  state_d = ST_NWA;
                  stb_d   = 1'b1;
                  adr_d   = regpc_q;
               end else if (need_b_s) begin
                  state_d = ST_NWB;
                  stb_d   = 1'b1;
                  adr_d   = regpc_q;
               end else begin
                  state_d = ST_HOLD;
                  vld_d   = 1'b1;
               end
            end

            ST_NWA: begin
               if (bus_ack_s) begin
                  nwa_d   = fb_dti;
                  regpc_d = regpc_q + 16'd1;
                  if (need_b_s) begin
                     // Back-to-back read: strobe stays up, address advances.
                     state_d = ST_NWB;
                     adr_d   = regpc_q + 16'd1;
                  end else begin
                     state_d = ST_HOLD;
                     stb_d   = 1'b0;
                     vld_d   = 1'b1;
                  end
               end else begin
                  state_d = ST_NWA;
               end
            end

            ST_NWB: begin
               if (bus_ack_s) begin
                  nwb_d   = fb_dti;
                  regpc_d = regpc_q + 16'd1;
                  stb_d   = 1'b0;
                  vld_d   = 1'b1;
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_NWB;
               end
            end

            ST_HOLD: begin
               if (vld_q && dec_rdy) begin
                  // Bundle consumed: next fetch strobes straight away.
                  vld_d   = 1'b0;
                  state_d = ST_FETCH;
                  stb_d   = 1'b1;
                  adr_d   = regpc_q;
               end else begin
                  state_d = ST_HOLD;
               end
            end

            default: begin
               state_d = ST_FETCH;
               stb_d   = 1'b0;
               vld_d   = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
         regpc_q <= RESET_PC;
         adr_q   <= 16'h0000;
         stb_q   <= 1'b0;
         vld_q   <= 1'b0;
         opc_q   <= 4'h0;
         ea_a_q  <= 6'h00;
         ea_b_q  <= 6'h00;
         nwa_q   <= 16'h0000;
         nwb_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         regpc_q <= regpc_d;
         adr_q   <= adr_d;
         stb_q   <= stb_d;
         vld_q   <= vld_d;
         opc_q   <= opc_d;
         ea_a_q  <= ea_a_d;
         ea_b_q  <= ea_b_d;
         nwa_q   <= nwa_d;
         nwb_q   <= nwb_d;
      end
   end

   assign fb_adr  = adr_q;
   assign fb_stb  = stb_q;
   assign fb_ena  = stb_q;
   assign fb_wre  = 1'b0;
   assign regPC   = regpc_q;
   assign opc     = opc_q;
   assign ea_a    = ea_a_q;
   assign ea_b    = ea_b_q;
   assign nwa     = nwa_q;
   assign nwb     = nwb_q;
   assign dec_vld = vld_q;

endmodule

// File: doc/dcpu16_fbus.md
Name: dcpu16_fbus

Overview:
- Instruction fetch stage of the DCPU16 core.
- Owns the program counter and issues read-only Simplified Wishbone reads for the instruction word, then for any operand "next words".
- Splits the instruction into opcode and the a/b operand fields (ea codes 0x00-0x3f) and hands a complete instruction downstream with a valid/ready handshake.
- Downstream consumers are the A/B bus address calculator and the decoder.

Parameters:
- RESET_PC, 16'h0000, value loaded into regPC on reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fb_adr  out  16  fetch address
- fb_stb  out  1  strobe; held until ack
- fb_ena  out  1  equals fb_stb
- fb_wre  out  1  constant 0 (read-only)
- fb_dti  in  16  read data
- fb_ack  in  1  read acknowledge; data valid this cycle
- pc_ld  in  1  branch/skip: load PC from pc_dat and flush
- pc_dat  in  16  new PC value
- regPC  out  16  PC of the next word to fetch
- opc  out  4  instruction bits [3:0]
- ea_a  out  6  instruction bits [9:4]
- ea_b  out  6  instruction bits [15:10]
- nwa  out  16  next word for operand a (0 when not fetched)
- nwb  out  16  next word for operand b (0 when not fetched)
- dec_vld  out  1  instruction bundle valid
- dec_rdy  in  1  downstream accepts the bundle

Behaviour:
- Reset:
  - regPC=RESET_PC; fb_adr=0, fb_stb=0, dec_vld=0.
  - opc, ea_a, ea_b, nwa, nwb all 0.
  - State=FETCH; first strobe is asserted on the cycle after rst deasserts.
  - Reset mid-transfer drops stb immediately; an ack in the reset cycle is ignored.
- States: FETCH, DECODE, NWA, NWB, HOLD.
- FETCH:
  - fb_stb=1, fb_adr=regPC.
  - On fb_ack: ir<=fb_dti, regPC<=regPC+1, stb deasserts next cycle, go to DECODE.
  - Zero-wait ack (in the first stb cycle) is legal.
- DECODE (one cycle, no bus activity):
  - need_a = (opc!=0) AND (ea_a in 0x10-0x17, 0x1e, 0x1f).
  - need_b = ea_b in the same set.
  - Next state: need_a -> NWA; else need_b -> NWB; else HOLD.
  - nwa and nwb are cleared to 0 in this cycle.
- NWA: stb with fb_adr=regPC; on ack nwa<=fb_dti, regPC++, then need_b ? NWB : HOLD.
- NWB: stb with fb_adr=regPC; on ack nwb<=fb_dti, regPC++, go to HOLD.
- HOLD:
  - dec_vld=1 and the bundle is stable.
  - On dec_vld&&dec_rdy: dec_vld<=0, go to FETCH.
  - Next strobe is asserted the following cycle.
- Non-basic instructions (opc==0): ea_a holds the sub-opcode and never triggers an a next-word fetch.
- PC arithmetic: 16-bit modulo; 0xFFFF+1 wraps to 0x0000. A next word fetched at 0x0000 after an instruction at 0xFFFF is legal.
- pc_ld (highest priority, any state):
  - regPC<=pc_dat, fb_stb<=0, dec_vld<=0, go to FETCH.
  - An fb_ack coincident with pc_ld is discarded: no capture, no increment.
  - pc_ld coincident with dec_rdy in HOLD: the flush wins and the bundle is dropped.
- Bus: at most one outstanding read. stb/adr change only on ack, pc_ld or rst.
- Throughput, no wait states:
  - 1-word instruction: 3 cycles (FETCH, DECODE, HOLD with rdy=1).
  - Each next word adds 1 cycle.

Decomposition:
- Shared package dcpu16_pkg holds:
  - state encoding constants for FETCH/DECODE/NWA/NWB/HOLD;
  - ea code constants (EA_REG, EA_IND, EA_IDX, EA_POP, EA_PEEK, EA_PUSH, EA_SP, EA_PC, EA_O, EA_NWI, EA_NWL);
  - OPC_NONBASIC=4'h0.
- One sub-module: dcpu16_nwdet, a combinational ea->needs-next-word detector, instantiated twice. The abus calculator reuses it.

Test Plan:
- Reset with RESET_PC=0, memory[0]=16'h7C01 (SET A,0x1234 literal), memory[1]=16'h1234, zero-wait ack, rdy=1 -> adr sequence 0,1; opc=1, ea_a=0, ea_b=0x1f, nwa=0, nwb=0x1234; dec_vld pulses at cycle 5; regPC=2.
- Instruction 16'h7DE1 with words 0x0100, 0x0200 (a=0x1e, b=0x1f) -> two next-word reads in order a then b; nwa=0x0100, nwb=0x0200, regPC+=3.
- Non-basic opc=0 with ea_a field=0x1f, ea_b=0x00 -> no extra read; nwa=0, dec_vld after 3 cycles.
- Start at PC=0xFFFF with an instruction needing one next word -> reads at 0xFFFF then 0x0000; regPC=0x0001.
- Ack delayed 3 cycles, pc_ld=1 with pc_dat=0x0040 on the 2nd wait cycle -> stb drops, late ack ignored, next read at 0x0040, no dec_vld for the dropped instruction.
- HOLD with dec_rdy=0 for 5 cycles -> bundle and dec_vld stable, no stb. Then rdy=1 -> FETCH strobe on the next cycle at the correct PC.
